// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file: NUM_WR write ports, NUM_RD registered read ports,
// write-first bypass and a registered write-collision flag. Optional macro: ZERO_REG_EN (reg 0 reads as 0).
module reg_file_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NUM_RD = 3,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     RESET,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic                     wr_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]        mem      [DEPTH];
    logic [DATA_W-1:0]        mem_next [DEPTH];
    logic [NUM_WR-1:0]        wr_act;
    logic [DEPTH-1:0]         wr_hit;
    logic                     conflict_next;
    logic [NUM_RD*DATA_W-1:0] rd_data_next;

    // Effective write enables; with a hardwired zero register, writes to 0 vanish entirely.
    always_comb begin
        for (int i = 0; i < NUM_WR; i++) begin
            wr_act[i] = wr_en[i];
`ifdef ZERO_REG_EN
            if (wr_addr[i*ADDR_W +: ADDR_W] == '0) begin
                wr_act[i] = 1'b0;
            end
`endif
        end
    end

    // Ports are scanned in ascending order so the highest-index port overwrites the others.
    always_comb begin
        conflict_next = 1'b0;
        wr_hit        = '0;
        for (int a = 0; a < DEPTH; a++) begin
            mem_next[a] = mem[a];
        end
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_act[i]) begin
                if (wr_hit[wr_addr[i*ADDR_W +: ADDR_W]]) begin
                    conflict_next = 1'b1;
                end
                wr_hit[wr_addr[i*ADDR_W +: ADDR_W]]   = 1'b1;
                mem_next[wr_addr[i*ADDR_W +: ADDR_W]] = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // rd_en is a request with no backpressure: every request is accepted, and rd_valid[j]
    // is high for exactly the one cycle after it, qualifying rd_data[j] (held otherwise).
    // Reading from mem_next gives write-first bypass.
    always_comb begin
        rd_data_next = rd_data;
        for (int j = 0; j < NUM_RD; j++) begin
            if (rd_en[j]) begin
                rd_data_next[j*DATA_W +: DATA_W] = mem_next[rd_addr[j*ADDR_W +: ADDR_W]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] <= '0;
            end
            rd_data     <= '0;
            rd_valid    <= '0;
            wr_conflict <= 1'b0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] <= mem_next[a];
            end
            rd_data     <= rd_data_next;
            rd_valid    <= rd_en;
            wr_conflict <= conflict_next;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (default parameters); expectations follow ZERO_REG_EN when defined.
module tb_reg_file_mp;

    logic        clk;
    logic        RESET;
    logic [1:0]  wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  rd_en;
    logic [8:0]  rd_addr;
    logic [47:0] rd_data;
    logic [2:0]  rd_valid;
    logic        wr_conflict;

`ifdef ZERO_REG_EN
    localparam bit Z = 1'b1;
`else
    localparam bit Z = 1'b0;
`endif

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .NUM_WR(2)) dut (
        .clk         (clk),
        .RESET       (RESET),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_conflict (wr_conflict)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [51:0] exp_q[$];
    logic [47:0] exp_hold = '0;
    logic [15:0] mdl [8];

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [2:0]  re;
        logic [8:0]  ra;
        logic [47:0] ed;
        logic        ec;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // driver: applies one cycle of stimulus, pushes its expectation, compares after the edge
    task automatic drive(input logic rst, input logic [1:0] we, input logic [5:0] wa,
                         input logic [31:0] wd, input logic [2:0] re, input logic [8:0] ra,
                         input logic [47:0] ed, input logic ec, input string tag);
        logic [51:0] e;
        RESET   = rst;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        if (rst) begin
            exp_hold = '0;
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (re[j]) exp_hold[j*16 +: 16] = ed[j*16 +: 16];
            end
        end
        exp_q.push_back({rst ? 1'b0 : ec, rst ? 3'b000 : re, exp_hold});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_queue: got empty want entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_conflict"}, {47'd0, wr_conflict}, {47'd0, e[51]});
            check({tag, "_valid"}, {45'd0, rd_valid}, {45'd0, e[50:48]});
            for (int j = 0; j < 3; j++) begin
                check($sformatf("%s_data%0d", tag, j), {32'd0, rd_data[j*16 +: 16]},
                      {32'd0, e[j*16 +: 16]});
            end
        end
    endtask

    initial begin
        logic [15:0] r0a, r0b, r0c;
        logic [1:0]  we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [2:0]  re;
        logic [8:0]  ra;
        logic [47:0] ed;
        logic        ec;
        logic [15:0] nxt [8];

        r0a = Z ? 16'h0000 : 16'h0001;
        r0b = Z ? 16'h0000 : 16'hFFFF;
        r0c = Z ? 16'h0000 : 16'h1234;

        // reset held two cycles with activity on the inputs, then read every register
        drive(1'b1, 2'b11, {3'd4, 3'd4}, 32'hDEAD_BEEF, 3'b111, 9'o444, 48'd0, 1'b1, "rst0");
        drive(1'b1, 2'b11, {3'd1, 3'd1}, 32'h1234_5678, 3'b111, 9'o111, 48'd0, 1'b1, "rst1");
        drive(1'b0, 2'b00, 6'd0, 32'd0, 3'b111, {3'd2, 3'd1, 3'd0}, 48'd0, 1'b0, "rd012");
        drive(1'b0, 2'b00, 6'd0, 32'd0, 3'b111, {3'd5, 3'd4, 3'd3}, 48'd0, 1'b0, "rd345");
        drive(1'b0, 2'b00, 6'd0, 32'd0, 3'b011, {3'd0, 3'd7, 3'd6}, 48'd0, 1'b0, "rd67");

        vecs.push_back('{1'b0, 2'b01, {3'd0, 3'd0}, {16'h0, 16'h0001}, 3'b000, 9'd0, 48'd0, 1'b0});
        vecs.push_back('{1'b0, 2'b01, {3'd0, 3'd1}, {16'h0, 16'h0002}, 3'b000, 9'd0, 48'd0, 1'b0});
        vecs.push_back('{1'b0, 2'b01, {3'd0, 3'd2}, {16'h0, 16'h0003}, 3'b000, 9'd0, 48'd0, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 6'd0, 32'd0, 3'b111, {3'd2, 3'd1, 3'd0},
                         {16'h0003, 16'h0002, r0a}, 1'b0});
        vecs.push_back('{1'b0, 2'b10, {3'd3, 3'd0}, {16'h0004, 16'h0}, 3'b000, 9'd0, 48'd0, 1'b0});
        vecs.push_back('{1'b0, 2'b10, {3'd4, 3'd0}, {16'h0005, 16'h0}, 3'b000, 9'd0, 48'd0, 1'b0});
        vecs.push_back('{1'b0, 2'b10, {3'd5, 3'd0}, {16'h0006, 16'h0}, 3'b000, 9'd0, 48'd0, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 6'd0, 32'd0, 3'b111, {3'd5, 3'd4, 3'd3},
                         {16'h0006, 16'h0005, 16'h0004}, 1'b0});
        vecs.push_back('{1'b0, 2'b01, {3'd0, 3'd5}, {16'h0, 16'h00AA}, 3'b111, {3'd5, 3'd4, 3'd5},
                         {16'h00AA, 16'h0005, 16'h00AA}, 1'b0});
        vecs.push_back('{1'b0, 2'b11, {3'd2, 3'd2}, {16'h2222, 16'h1111}, 3'b000, 9'd0, 48'd0, 1'b1});
        vecs.push_back('{1'b0, 2'b00, 6'd0, 32'd0, 3'b100, {3'd2, 3'd0, 3'd0},
                         {16'h2222, 32'd0}, 1'b0});
        vecs.push_back('{1'b0, 2'b11, {3'd7, 3'd6}, {16'h0707, 16'h0606}, 3'b011, {3'd0, 3'd7, 3'd6},
                         {16'h0, 16'h0707, 16'h0606}, 1'b0});
        vecs.push_back('{1'b0, 2'b11, {3'd3, 3'd3}, {16'hBBBB, 16'hAAAA}, 3'b111, {3'd3, 3'd3, 3'd3},
                         {16'hBBBB, 16'hBBBB, 16'hBBBB}, 1'b1});
        vecs.push_back('{1'b0, 2'b00, 6'd0, 32'd0, 3'b111, {3'd7, 3'd6, 3'd3},
                         {16'h0707, 16'h0606, 16'hBBBB}, 1'b0});
        vecs.push_back('{1'b0, 2'b11, {3'd0, 3'd0}, {16'hFFFF, 16'hFFFF}, 3'b001, 9'd0,
                         {32'd0, r0b}, !Z});
        vecs.push_back('{1'b0, 2'b00, 6'd0, 32'd0, 3'b110, {3'd5, 3'd0, 3'd0},
                         {16'h00AA, r0b, 16'h0}, 1'b0});
        vecs.push_back('{1'b0, 2'b11, {3'd1, 3'd0}, {16'h5678, 16'h1234}, 3'b011, {3'd0, 3'd1, 3'd0},
                         {16'h0, 16'h5678, r0c}, 1'b0});

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].re, vecs[k].ra,
                  vecs[k].ed, vecs[k].ec, $sformatf("vec%0d", k));
        end

        // reset in mid-stream, with a write and reads in the reset cycle
        drive(1'b0, 2'b01, {3'd0, 3'd7}, {16'h0, 16'hBEEF}, 3'b000, 9'd0, 48'd0, 1'b0, "mid_wr7");
        drive(1'b1, 2'b10, {3'd6, 3'd0}, {16'h1234, 16'h0}, 3'b111, {3'd6, 3'd7, 3'd6},
              48'd0, 1'b0, "mid_rst");
        drive(1'b0, 2'b00, 6'd0, 32'd0, 3'b111, {3'd5, 3'd6, 3'd7}, 48'd0, 1'b0, "mid_rd");
        drive(1'b0, 2'b00, 6'd0, 32'd0, 3'b000, 9'd0, 48'd0, 1'b0, "mid_hold");

        // random traffic against a behavioural model, starting from a clean reset
        drive(1'b1, 2'b00, 6'd0, 32'd0, 3'b000, 9'd0, 48'd0, 1'b0, "rnd_rst");
        for (int a = 0; a < 8; a++) mdl[a] = '0;
        for (int n = 0; n < 60; n++) begin
            we = 2'($urandom_range(0, 3));
            wa = 6'($urandom_range(0, 63));
            wd = $urandom();
            re = 3'($urandom_range(0, 7));
            ra = 9'($urandom_range(0, 511));
            for (int a = 0; a < 8; a++) nxt[a] = mdl[a];
            for (int i = 0; i < 2; i++) begin
                if (we[i] && !(Z && wa[i*3 +: 3] == 3'd0)) nxt[wa[i*3 +: 3]] = wd[i*16 +: 16];
            end
            ec = (we == 2'b11) && (wa[2:0] == wa[5:3]) && !(Z && wa[2:0] == 3'd0);
            for (int j = 0; j < 3; j++) ed[j*16 +: 16] = nxt[ra[j*3 +: 3]];
            drive(1'b0, we, wa, wd, re, ra, ed, ec, $sformatf("rnd%0d", n));
            for (int a = 0; a < 8; a++) mdl[a] = nxt[a];
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
